fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble written into the FD register.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pc_en  in  1  PC_ENABLE from the control unit's cw_out; permits consuming an instruction.
REQ-006 fd_en  in  1  FD_REG_EN from the control unit's cw_out; FD register update enable.
REQ-007 redirect  in  1  taken branch or jump, or mispredict (same cycle as chng2nop).
REQ-008 redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-009 imem_req  out  1  instruction-memory request.
REQ-010 imem_addr  out  32  request address, word aligned.
REQ-011 imem_gnt  in  1  memory accepts the request this cycle.
REQ-012 imem_rvalid  in  1  read data valid.
REQ-013 imem_rdata  in  32  read data.
REQ-014 instr_out  out  32  FD register instruction; drives the control unit's instr_in.
REQ-015 pc_out  out  32  PC of instr_out.
REQ-016 instr_valid  out  1  instr_out is a real instruction, not a bubble.
REQ-017 stall  out  1  no fetched instruction is available; drives the control unit's stall.

Function
REQ-018 States: RESET, RUN, DRAIN.
  - RESET -> RUN on the first cycle with rst=0.
  - RUN -> DRAIN on redirect while a request is outstanding and imem_rvalid=0.
  - DRAIN -> RUN on imem_rvalid.
REQ-019 Fetch PC register fpc:
  - imem_addr = fpc.
  - On imem_req & imem_gnt, fpc <= fpc+4 (32-bit wrap, 0xFFFF_FFFC -> 0) and the request PC is latched.
REQ-020 At most one outstanding request; imem_req=1 only in RUN, with no outstanding request, (fifo_count + outstanding) < 2, and redirect=0.
REQ-021 imem_req is held with a stable imem_addr until imem_gnt; imem_gnt is ignored when imem_req=0.
REQ-022 Instruction FIFO:
  - 2 entries of {pc, instr}.
  - imem_rvalid in RUN with a request outstanding pushes {latched PC, imem_rdata} and clears outstanding.
  - Overflow is impossible by REQ-020.
REQ-023 stall = (fifo_count == 0), combinational.
REQ-024 FD register update when fd_en=1 and redirect=0:
  - FIFO non-empty and pc_en=1: load the head, pop it, instr_valid=1.
  - Otherwise: load NOP_INSTR, instr_valid=0, pc_out held.
REQ-025 When fd_en=0 and redirect=0: FD register and FIFO hold.
REQ-026 Push and pop in the same cycle: fifo_count unchanged, FIFO order preserved.
REQ-027 redirect has priority over all other events in the same cycle:
  - FIFO flushed.
  - fpc <= {redirect_pc[31:2], 2'b00}.
  - instr_out <= NOP_INSTR, instr_valid <= 0.
  - Any same-cycle imem_rvalid data is discarded.
REQ-028 In DRAIN:
  - imem_req=0.
  - The returning response is discarded (no push).
  - A further redirect only updates fpc.
REQ-029 Fetch-to-FD latency: request accepted in cycle N, rvalid in cycle M>=N+1, FD loaded at the earliest in M+1 with fd_en=pc_en=1.

Reset
REQ-030 While rst=1 at a clock edge:
  - state=RESET, fpc=RESET_PC, FIFO empty, outstanding=0, DRAIN cleared.
  - instr_out=NOP_INSTR, pc_out=0, instr_valid=0.
  - imem_req=0, stall=1.
REQ-031 rst asserted mid-transaction abandons the outstanding request; an imem_rvalid arriving while rst=1 or in the first cycle after reset is ignored.

Verification
REQ-032 Zero-wait memory (gnt same cycle, rvalid next cycle), fd_en=pc_en=1 -> instr_out carries PCs 0,4,8,... one per 2 cycles; instr_valid pulses accordingly; the first instr_valid=1 appears 3 cycles after reset release.
REQ-033 fd_en=0 for 5 cycles with memory responding -> exactly 2 instructions buffered, imem_req=0, stall=0; on fd_en=1 they emerge in order, PC 0 then 4.
REQ-034 redirect with redirect_pc=0x0000_0103 while a request is outstanding -> DRAIN; the stale rvalid data is dropped; the next imem_addr is 0x0000_0100; one NOP bubble with instr_valid=0.
REQ-035 redirect in the same cycle as imem_rvalid and a FIFO pop -> FIFO empty, no push, fpc=redirect target, state RUN.
REQ-036 fpc=0xFFFF_FFFC granted -> next imem_addr is 0x0000_0000.
REQ-037 rst asserted for 1 cycle with 2 entries buffered and a request outstanding -> all outputs at reset values; a later rvalid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It issues one word-aligned request at a time to the
// instruction memory and buffers returned instructions in a 2-entry {pc, instr}
// FIFO. The FD pipeline register is loaded from that FIFO, or with a NOP bubble
// when nothing can be consumed. A redirect (taken branch, jump or mispredict)
// flushes everything. If a request is still in flight when the redirect
// arrives, the unit enters DRAIN and discards that stale response.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   pc_en        control unit permits consuming an instruction
//   fd_en        FD register update enable
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   imem_req     instruction-memory request
//   imem_addr    request address (word aligned)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid
//   imem_rdata   read data
//   instr_out    FD register instruction
//   pc_out       PC of instr_out
//   instr_valid  instr_out is a real instruction, not a bubble
//   stall        no fetched instruction is available
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        fd_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        stall
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;        // next address to fetch
  logic [31:0] req_pc_q, req_pc_d;  // PC of the request in flight
  logic        outst_q, outst_d;    // one request in flight

  // Two-entry FIFO: the storage is not reset, only pointers and count are.
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  // FD register
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic        grant;
  logic        push;
  logic        pop;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A new request needs a free FIFO slot for its eventual response. With no
  // request in flight, (count + outstanding) < 2 reduces to count < 2.
  assign imem_req  = (state_q == ST_RUN) && !outst_q && (count_q < 2'd2) && !redirect;
  assign imem_addr = fpc_q;
  assign grant     = imem_req && imem_gnt;

  // Responses are only kept in RUN; in DRAIN, or under a same-cycle redirect,
  // they belong to a discarded fetch path.
  assign push = (state_q == ST_RUN) && outst_q && imem_rvalid && !redirect;
  assign pop  = fd_en && pc_en && !redirect && (count_q != 2'd0);

  assign stall       = (count_q == 2'd0);
  assign instr_out   = instr_q;
  assign pc_out      = pc_q;
  assign instr_valid = valid_q;

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the logic below can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    outst_d  = outst_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    valid_d  = valid_q;

    unique case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   if (redirect && outst_q && !imem_rvalid) state_d = ST_DRAIN;
      ST_DRAIN: if (imem_rvalid) state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase

    // A grant needs no request in flight, so it never coincides with a response.
    if (grant) begin
      outst_d = 1'b1;
    end else if (outst_q && imem_rvalid) begin
      outst_d = 1'b0;
    end

    if (redirect) begin
      fpc_d = redirect_tgt;
    end else if (grant) begin
      fpc_d    = fpc_q + 32'd4;  // wraps 0xFFFF_FFFC -> 0
      req_pc_d = fpc_q;
    end

    if (redirect) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end

    // Bubbles keep the old pc_out; only real instructions move it.
    if (redirect) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (fd_en) begin
      if (pop) begin
        instr_d = fifo_instr_q[rd_ptr_q];
        pc_d    = fifo_pc_q[rd_ptr_q];
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RESET;
      fpc_q    <= RESET_PC;
      req_pc_q <= RESET_PC;
      outst_q  <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      instr_q  <= NOP_INSTR;
      pc_q     <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
      outst_q  <= outst_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: FIFO storage has no reset; the count and pointers alone decide what
  // is valid, so a stray write while rst is high is never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
